// File: rtl/bypass_pkg.sv
// Shared types for the operand bypass unit: stage indices, in-flight tag record, default widths.
package bypass_pkg;

    localparam int DEF_NUM_PIPES = 2;
    localparam int DEF_NUM_SRC   = 3;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_RADDR_W   = 3;
    localparam int DEF_SCNT_W    = 16;
    localparam int NUM_STAGES    = 3;

    typedef enum logic [1:0] {
        S2 = 2'd0,
        S3 = 2'd1,
        S4 = 2'd2
    } stage_e;

    // num width is the regfile address width used throughout the core
    typedef struct packed {
        logic                   valid;
        logic                   we;
        logic                   load;
        logic [DEF_RADDR_W-1:0] num;
    } tag_t;

    function automatic logic tag_match(input tag_t t, input logic [DEF_RADDR_W-1:0] n,
                                       input logic use_b);
        return t.valid & t.we & (t.num == n) & use_b;
    endfunction

endpackage

// File: rtl/operand_bypass_unit_if.sv
// Stage-1 operand/result bus between the pipeline control and the bypass unit.
interface operand_bypass_unit_if #(
    parameter int NUM_PIPES = 2,
    parameter int NUM_SRC   = 3,
    parameter int DATA_W    = 16,
    parameter int RADDR_W   = 3,
    parameter int SCNT_W    = 16
);
    logic [NUM_PIPES-1:0]                 issue_i;
    logic [NUM_PIPES-1:0]                 dst_we_i;
    logic [NUM_PIPES*RADDR_W-1:0]         dst_num_i;
    logic [NUM_PIPES-1:0]                 is_load_i;
    logic [NUM_PIPES*NUM_SRC*RADDR_W-1:0] src_num_i;
    logic [NUM_PIPES*NUM_SRC-1:0]         src_use_i;
    logic [NUM_PIPES*NUM_SRC*DATA_W-1:0]  reg_data_i;
    logic [NUM_PIPES*DATA_W-1:0]          res2_i;
    logic [NUM_PIPES*DATA_W-1:0]          res3_i;
    logic [NUM_PIPES*DATA_W-1:0]          wb_i;
    logic                                 flush_i;
    logic [NUM_PIPES*NUM_SRC*DATA_W-1:0]  opnd_o;
    logic                                 stall_o;
    logic [SCNT_W-1:0]                    stall_cnt_o;

    modport master (
        output issue_i, dst_we_i, dst_num_i, is_load_i, src_num_i, src_use_i,
               reg_data_i, res2_i, res3_i, wb_i, flush_i,
        input  opnd_o, stall_o, stall_cnt_o
    );

    modport slave (
        input  issue_i, dst_we_i, dst_num_i, is_load_i, src_num_i, src_use_i,
               reg_data_i, res2_i, res3_i, wb_i, flush_i,
        output opnd_o, stall_o, stall_cnt_o
    );
endinterface

// File: rtl/bypass_src_mux.sv
// Priority forwarding select for one stage-1 source operand, plus its load-use hazard flag.
module bypass_src_mux
    import bypass_pkg::*;
#(
    parameter int NUM_PIPES = DEF_NUM_PIPES,
    parameter int DATA_W    = DEF_DATA_W
) (
    input  tag_t [NUM_STAGES*NUM_PIPES-1:0] tags_i,
    input  logic [DEF_RADDR_W-1:0]          src_num_i,
    input  logic                            src_use_i,
    input  logic [DATA_W-1:0]               reg_data_i,
    input  logic [NUM_PIPES*DATA_W-1:0]     res2_i,
    input  logic [NUM_PIPES*DATA_W-1:0]     res3_i,
    input  logic [NUM_PIPES*DATA_W-1:0]     wb_i,
    output logic [DATA_W-1:0]               opnd_o,
    output logic                            hazard_o
);

    // Walk oldest stage / lowest pipe first so later matches override:
    // the newest stage and, within it, the highest pipe index end up winning.
    always_comb begin
        opnd_o   = reg_data_i;
        hazard_o = 1'b0;
        for (int s = NUM_STAGES - 1; s >= 0; s--) begin
            for (int p = 0; p < NUM_PIPES; p++) begin
                if (tag_match(tags_i[s*NUM_PIPES+p], src_num_i, src_use_i)) begin
                    hazard_o = (s == int'(S2)) && tags_i[s*NUM_PIPES+p].load;
                    if (s == int'(S2)) begin
                        opnd_o = res2_i[p*DATA_W +: DATA_W];
                    end else if (s == int'(S3)) begin
                        opnd_o = res3_i[p*DATA_W +: DATA_W];
                    end else begin
                        opnd_o = wb_i[p*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/operand_bypass_unit.sv
// Operand forwarding and load-use interlock: in-flight tag pipe, per-source muxes, stall counter.
module operand_bypass_unit
    import bypass_pkg::*;
#(
    parameter int NUM_PIPES = DEF_NUM_PIPES,
    parameter int NUM_SRC   = DEF_NUM_SRC,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RADDR_W   = DEF_RADDR_W,
    parameter int SCNT_W    = DEF_SCNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    operand_bypass_unit_if.slave bus
);

    tag_t [NUM_STAGES*NUM_PIPES-1:0] tags_q, tags_d;
    logic [SCNT_W-1:0]               cnt_q, cnt_d;
    logic [NUM_PIPES*NUM_SRC-1:0]    hazard;
    logic [NUM_PIPES*NUM_SRC*DATA_W-1:0] opnd;
    logic                            stall;

    assign stall           = |hazard;
    assign bus.stall_o     = stall;
    assign bus.stall_cnt_o = cnt_q;
    assign bus.opnd_o      = opnd;

    // A stalled or flushed bundle leaves a bubble in stage 2; flush wins regardless of stall.
    always_comb begin
        tags_d = tags_q;
        for (int p = 0; p < NUM_PIPES; p++) begin
            tags_d[int'(S4)*NUM_PIPES+p] = tags_q[int'(S3)*NUM_PIPES+p];
            tags_d[int'(S3)*NUM_PIPES+p] = tags_q[int'(S2)*NUM_PIPES+p];
            tags_d[int'(S2)*NUM_PIPES+p].valid = bus.issue_i[p] & ~stall & ~bus.flush_i;
            tags_d[int'(S2)*NUM_PIPES+p].we    = bus.dst_we_i[p];
            tags_d[int'(S2)*NUM_PIPES+p].load  = bus.is_load_i[p];
            tags_d[int'(S2)*NUM_PIPES+p].num   = bus.dst_num_i[p*RADDR_W +: RADDR_W];
        end
        cnt_d = (stall && (cnt_q != '1)) ? cnt_q + SCNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tags_q <= '0;
            cnt_q  <= '0;
        end else begin
            tags_q <= tags_d;
            cnt_q  <= cnt_d;
        end
    end

    for (genvar p = 0; p < NUM_PIPES; p++) begin : g_pipe
        for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
            localparam int IDX = p*NUM_SRC + s;
            bypass_src_mux #(
                .NUM_PIPES (NUM_PIPES),
                .DATA_W    (DATA_W)
            ) u_mux (
                .tags_i     (tags_q),
                .src_num_i  (bus.src_num_i[IDX*RADDR_W +: RADDR_W]),
                .src_use_i  (bus.src_use_i[IDX]),
                .reg_data_i (bus.reg_data_i[IDX*DATA_W +: DATA_W]),
                .res2_i     (bus.res2_i),
                .res3_i     (bus.res3_i),
                .wb_i       (bus.wb_i),
                .opnd_o     (opnd[IDX*DATA_W +: DATA_W]),
                .hazard_o   (hazard[IDX])
            );
        end
    end

endmodule
